// File: rtl/subbytes_arbiter_if.sv
// Requester/consumer handshakes and the link to the shared SubBytes unit.
interface subbytes_arbiter_if;
  logic         req_c_valid;
  logic [127:0] req_c_data;
  logic         req_c_ready;
  logic         resp_c_valid;
  logic [127:0] resp_c_data;
  logic         resp_c_ready;
  logic         req_k_valid;
  logic [31:0]  req_k_data;
  logic         req_k_ready;
  logic         resp_k_valid;
  logic [31:0]  resp_k_data;
  logic         resp_k_ready;
  logic [127:0] sub_in;
  logic [127:0] sub_out;
  logic         busy;

  modport slave (
    input  req_c_valid, req_c_data, resp_c_ready,
    input  req_k_valid, req_k_data, resp_k_ready,
    input  sub_out,
    output req_c_ready, resp_c_valid, resp_c_data,
    output req_k_ready, resp_k_valid, resp_k_data,
    output sub_in, busy
  );

  modport master (
    output req_c_valid, req_c_data, resp_c_ready,
    output req_k_valid, req_k_data, resp_k_ready,
    output sub_out,
    input  req_c_ready, resp_c_valid, resp_c_data,
    input  req_k_ready, resp_k_valid, resp_k_data,
    input  sub_in, busy
  );
endinterface

// File: rtl/subbytes_arbiter.sv
// Shares one combinational 128-bit SubBytes bank between the cipher round
// datapath (C, full state) and key expansion (K, 32-bit SubWord).
//
//   state | meaning
//   IDLE  | arbitrating; ready asserted combinationally for the winner
//   SUB   | op_reg drives the S-box bank; result captured into res_reg
//   RESP  | result offered to the owner until its consumer takes it
module subbytes_arbiter #(
  parameter int FIXED_PRIORITY = 0
) (
  input logic              clk,
  input logic              rst,
  subbytes_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic OWN_C = 1'b0;
  localparam logic OWN_K = 1'b1;

  state_t       state, state_nxt;
  logic [127:0] op_reg, res_reg;
  logic         owner, last_grant;
  logic         grant_c, grant_k;
  logic         resp_c_valid, resp_k_valid;

  // Arbitration, next state and response valids; everything forced low in reset
  always_comb begin
    state_nxt    = state;
    grant_c      = 1'b0;
    grant_k      = 1'b0;
    resp_c_valid = 1'b0;
    resp_k_valid = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_c_valid && bus.req_k_valid) begin
          if (FIXED_PRIORITY != 0 || last_grant == OWN_C) grant_k = 1'b1;
          else                                            grant_c = 1'b1;
        end else begin
          grant_c = bus.req_c_valid;
          grant_k = bus.req_k_valid;
        end
        if (grant_c || grant_k) state_nxt = SUB;
      end
      SUB: state_nxt = RESP;
      RESP: begin
        resp_c_valid = (owner == OWN_C);
        resp_k_valid = (owner == OWN_K);
        if ((resp_c_valid && bus.resp_c_ready) || (resp_k_valid && bus.resp_k_ready))
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      grant_c      = 1'b0;
      grant_k      = 1'b0;
      resp_c_valid = 1'b0;
      resp_k_valid = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operand/result capture and grant bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg     <= '0;
      res_reg    <= '0;
      owner      <= OWN_C;
      last_grant <= OWN_K;
    end else begin
      if (grant_c) begin
        op_reg     <= bus.req_c_data;
        owner      <= OWN_C;
        last_grant <= OWN_C;
      end else if (grant_k) begin
        op_reg     <= {96'h0, bus.req_k_data};
        owner      <= OWN_K;
        last_grant <= OWN_K;
      end
      if (state == SUB) res_reg <= bus.sub_out;
    end
  end

  assign bus.req_c_ready  = grant_c;
  assign bus.req_k_ready  = grant_k;
  assign bus.resp_c_valid = resp_c_valid;
  assign bus.resp_k_valid = resp_k_valid;
  assign bus.resp_c_data  = res_reg;
  assign bus.resp_k_data  = res_reg[31:0];
  assign bus.sub_in       = op_reg;
  assign bus.busy         = (state != IDLE) && !rst;

endmodule

// File: doc/subbytes_arbiter.md
# subbytes_arbiter

Time-shares one 128-bit SubBytes substitution unit (16 parallel S-boxes, purely combinational) between two requesters. The cipher round datapath submits full 128-bit states. The key-expansion logic submits 32-bit SubWord operands. The block arbitrates, registers the operand into the unit, captures the result, and returns it to the winning requester over a valid/ready handshake. It sits between the round controller/key scheduler and the single substitution instance, so the design needs only one S-box bank.

## Interface
Parameters:
- FIXED_PRIORITY, default 0: 0 = round-robin between requesters; 1 = key requester always wins a conflict.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- req_c_valid  input  1  cipher request valid.
- req_c_data  input  128  cipher state to substitute.
- req_c_ready  output  1  cipher request accepted this cycle.
- resp_c_valid  output  1  cipher result valid.
- resp_c_data  output  128  substituted cipher state.
- resp_c_ready  input  1  cipher consumer takes result.
- req_k_valid  input  1  key-expansion request valid.
- req_k_data  input  32  word to substitute.
- req_k_ready  output  1  key request accepted this cycle.
- resp_k_valid  output  1  key result valid.
- resp_k_data  output  32  substituted word.
- resp_k_ready  input  1  key consumer takes result.
- sub_in  output  128  operand driven to the substitution unit.
- sub_out  input  128  result from the substitution unit, combinational from sub_in.
- busy  output  1  high whenever state is not IDLE.

## Operation
- The FSM has three states: IDLE, SUB, RESP. Registers are op_reg[127:0], res_reg[127:0], owner (C/K) and last_grant (C/K).
- IDLE:
  - Arbitrate among the valid requests. A single valid request wins.
  - If both are valid:
    - With FIXED_PRIORITY=1, K wins.
    - Otherwise the requester that is not last_grant wins.
  - req_x_ready is 1 only for the winner, and is combinational from the valids.
  - On acceptance:
    - C loads op_reg <= req_c_data.
    - K loads op_reg <= {96'h0, req_k_data}.
    - owner and last_grant are set to the winner, and the FSM moves to SUB.
  - With no valid request, the FSM stays in IDLE and op_reg holds.
- SUB: sub_in = op_reg, which is driven in all states. res_reg <= sub_out, then go to RESP.
- RESP:
  - resp_<owner>_valid = 1.
  - resp_c_data = res_reg, and resp_k_data = res_reg[31:0]. Both data outputs are driven from res_reg at all times.
  - When resp_<owner>_ready is 1, go to IDLE. Otherwise hold; res_reg is stable.
- Only one transaction is in flight at a time. Both req_*_ready are 0 outside IDLE.
- The non-granted request is not dropped. Its requester must keep valid and data stable until it sees ready.
- Requester data changes while ready is low are ignored.

## Timing
- Reset (rst high at a clock edge):
  - State goes to IDLE, last_grant <= K, op_reg and res_reg <= 0, owner <= C.
  - While rst is high, all *_ready, resp_*_valid and busy are 0.
  - An in-flight transaction is discarded and no response is issued.
- Latency from accept edge (cycle 0) to response:
  - The SUB edge is cycle 1.
  - resp_valid is high from cycle 2.
- Minimum issue interval is 3 cycles, with resp_ready already high when resp_valid rises. Back-to-back accept is possible in the cycle after the handshake edge.
- busy is high in SUB and RESP and low in IDLE.
- On simultaneous valids, exactly one ready is high. Under round-robin, sustained contention alternates C, K, C, K. The first conflict after reset grants C.
- resp ready asserted without valid has no effect.

## Test plan
- Reset, then req_c_valid with req_c_data = 128'h00112233445566778899aabbccddeeff and resp_c_ready = 1:
  - req_c_ready is 1 at cycle 0.
  - resp_c_valid is 1 at cycle 2 with 128'h638293c31bfc33f5c4eeacea4bc12816.
  - The FSM is back in IDLE at cycle 3.
- Key request 32'hcf4f3c09 → resp_k_data = 32'h8a84eb01 at cycle 2. sub_in[127:32] = 0 throughout. resp_c_valid stays 0.
- Both valid continuously, FIXED_PRIORITY = 0:
  - Grant order after reset is C, K, C, K.
  - Each response appears on the correct port only.
- Same stimulus with FIXED_PRIORITY = 1: K is granted every time and C is starved while K stays valid.
- Backpressure: hold resp_c_ready = 0 for 5 cycles.
  - resp_c_valid and data stay stable.
  - Both req ready stay 0.
  - After ready rises, the FSM returns to IDLE on the next edge.
- Assert rst during SUB: the next edge clears busy and all valid outputs, and no stale response appears afterward.
